// File: rtl/exec_writeback_unit_pkg.sv
// exec_writeback_unit_pkg: op encodings, flag indices, FSM states and width defaults
package exec_writeback_unit_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 3;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_INV = 3'b001;
  localparam logic [2:0] OP_LOAD = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_NOP = 3'b100;
  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;
  typedef enum logic [1:0] {IDLE, WB, MEM} state_e;
endpackage

// File: rtl/exec_writeback_unit_wb_timeout_counter.sv
// wb_timeout_counter: counts cycles without ack; expired pulses on the cycle the count reaches MEM_TIMEOUT
// Ports: clk, rst_n (async active-low), clr (synchronous restart), en (count this cycle), expired (comb)
module wb_timeout_counter #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;
  assign expired = en && (cnt == 8'(MEM_TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + 8'd1 : cnt;
endmodule

// File: rtl/exec_writeback_unit.sv
// exec_writeback_unit: consumes executed ops; ALU ops write back and latch CCR, load/store drive a timed memory handshake
// Ports: ex_* execute handshake in, wb_* register-file write out, mem_* memory request/ack, ccr, sticky mem_err.
// Optional macro WB_BYPASS_EN adds byp_valid/byp_addr/byp_data/byp_ccr forwarding outputs.
module exec_writeback_unit
  import exec_writeback_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [2:0]        ex_op,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [3:0]        ex_flags,
  input  logic [DATA_W-1:0] ex_src,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        ccr,
  output logic              mem_err
`ifdef WB_BYPASS_EN
  ,
  output logic              byp_valid,
  output logic [REG_AW-1:0] byp_addr,
  output logic [DATA_W-1:0] byp_data,
  output logic [3:0]        byp_ccr
`endif
);
  state_e state, state_nx;
  logic [REG_AW-1:0] ld_rd;
  logic accept, is_alu, is_mem, expired;
  assign ex_ready = rst_n && (state == IDLE);
  assign accept = ex_valid && ex_ready;
  assign is_alu = (ex_op == OP_ADD) || (ex_op == OP_INV);
  assign is_mem = (ex_op == OP_LOAD) || (ex_op == OP_STORE);
  assign wb_en = (state == WB);
`ifdef WB_BYPASS_EN
  assign byp_valid = wb_en;
  assign byp_addr = wb_addr;
  assign byp_data = wb_data;
  assign byp_ccr = ccr;
`endif
  wb_timeout_counter #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state != MEM),
    .en(state == MEM && !mem_ack),
    .expired(expired)
  );
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = !accept ? IDLE : is_alu ? WB : is_mem ? MEM : IDLE;
    else if (state == WB) state_nx = IDLE;
    else if (state == MEM) state_nx = mem_ack ? (mem_we ? IDLE : WB) : expired ? IDLE : MEM;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wb_addr <= '0;
      wb_data <= '0;
      ld_rd <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      ccr <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        mem_err <= 1'b0;
        if (is_alu) begin
          ccr <= ex_flags;
          wb_addr <= ex_rd;
          wb_data <= ex_result;
        end
        if (is_mem) begin
          mem_addr <= ex_result;
          mem_we <= (ex_op == OP_STORE);
          mem_req <= 1'b1;
          ld_rd <= ex_rd;
        end
        if (ex_op == OP_STORE) mem_wdata <= ex_src;
      end
      if (state == MEM) begin
        if (mem_ack) begin
          mem_req <= 1'b0;
          if (!mem_we) begin
            wb_data <= mem_rdata;
            wb_addr <= ld_rd;
          end
        end else if (expired) begin
          mem_req <= 1'b0;
          mem_err <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_exec_writeback_unit.sv
// tb_exec_writeback_unit: directed checks of ALU writeback, load/store handshake, timeout and async reset
module tb_exec_writeback_unit;
  logic clk = 0, rst_n = 0, ex_valid = 0, mem_ack = 0;
  logic ex_ready, wb_en, mem_req, mem_we, mem_err;
  logic [2:0] ex_op = 0;
  logic [15:0] ex_result = 0, ex_src = 0, mem_rdata = 0, wb_data, mem_addr, mem_wdata;
  logic [3:0] ex_flags = 0, ccr;
  logic [2:0] ex_rd = 0, wb_addr;
  int errors = 0, checks = 0;
`ifdef WB_BYPASS_EN
  logic byp_valid;
  logic [2:0] byp_addr;
  logic [15:0] byp_data;
  logic [3:0] byp_ccr;
`endif
  exec_writeback_unit dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_result(ex_result), .ex_flags(ex_flags), .ex_src(ex_src), .ex_rd(ex_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ccr(ccr), .mem_err(mem_err)
`ifdef WB_BYPASS_EN
    , .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data), .byp_ccr(byp_ccr)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] op, input logic [15:0] res, input logic [3:0] fl,
                       input logic [15:0] src, input logic [2:0] rd);
    ex_valid = 1; ex_op = op; ex_result = res; ex_flags = fl; ex_src = src; ex_rd = rd;
    step();
    ex_valid = 0;
  endtask
  initial begin
    step(); step();
    chk("rst_ready", ex_ready, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ccr", ccr, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_wb_data", wb_data, 0);
    rst_n = 1; #1;
    chk("rel_ready", ex_ready, 1);
    step();
    issue(3'b000, 16'h0000, 4'b0011, 16'h0, 3'd2);
    chk("add_wb_en", wb_en, 1);
    chk("add_wb_addr", wb_addr, 2);
    chk("add_wb_data", wb_data, 16'h0000);
    chk("add_ccr", ccr, 4'b0011);
    chk("add_ready_low", ex_ready, 0);
`ifdef WB_BYPASS_EN
    chk("byp_valid", byp_valid, 1);
    chk("byp_addr", byp_addr, 2);
    chk("byp_ccr", byp_ccr, 4'b0011);
`endif
    step();
    chk("add_wb_done", wb_en, 0);
    chk("add_ready_back", ex_ready, 1);
    issue(3'b001, 16'h00FF, 4'b0100, 16'h0, 3'd7);
    chk("inv_wb", {wb_en, 1'b0, wb_addr, wb_data}, {1'b1, 1'b0, 3'd7, 16'h00FF});
    chk("inv_ccr", ccr, 4'b0100);
    step();
    chk("inv_hold", {wb_en, wb_addr, wb_data}, {1'b0, 3'd7, 16'h00FF});
    issue(3'b010, 16'h0040, 4'b1111, 16'h0, 3'd5);
    chk("ld_c1", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0040});
    chk("ld_ready_low", ex_ready, 0);
    step();
    chk("ld_c2", mem_req, 1);
    step();
    chk("ld_c3", mem_req, 1);
    mem_ack = 1; mem_rdata = 16'hBEEF;
    step();
    mem_ack = 0;
    chk("ld_req_drop", mem_req, 0);
    chk("ld_wb", {wb_en, 1'b0, wb_addr, wb_data}, {1'b1, 1'b0, 3'd5, 16'hBEEF});
    chk("ld_ccr", ccr, 4'b0100);
    step();
    chk("ld_idle", {ex_ready, wb_en}, 2'b10);
    issue(3'b011, 16'h1234, 4'b1111, 16'hA5A5, 3'd1);
    chk("st_req", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 16'h1234, 16'hA5A5});
    chk("st_no_wb", wb_en, 0);
    mem_ack = 1;
    step();
    mem_ack = 0;
    chk("st_done", {ex_ready, mem_req, wb_en}, 3'b100);
    chk("st_ccr", ccr, 4'b0100);
    issue(3'b010, 16'h0100, 4'b0000, 16'h0, 3'd3);
    for (int i = 1; i < 15; i++) begin
      chk("tmo_req_held", mem_req, 1);
      step();
    end
    chk("tmo_c15", {mem_req, mem_err}, 2'b10);
    step();
    chk("tmo_abort", {mem_req, mem_err, wb_en, ex_ready}, 4'b0101);
    step();
    chk("tmo_sticky", mem_err, 1);
    issue(3'b100, 16'h0, 4'b1111, 16'h0, 3'd0);
    chk("nop_clears_err", {mem_err, ex_ready, wb_en, mem_req}, 4'b0100);
    issue(3'b010, 16'h0200, 4'b0000, 16'h0, 3'd6);
    for (int i = 1; i < 15; i++) step();
    chk("edge_c15", mem_req, 1);
    mem_ack = 1; mem_rdata = 16'h1357;
    step();
    mem_ack = 0;
    chk("edge_ack_wins", {wb_en, mem_err, mem_req}, 3'b100);
    chk("edge_wb", {wb_addr, wb_data}, {3'd6, 16'h1357});
    step();
    issue(3'b100, 16'hFFFF, 4'b1111, 16'h0, 3'd1);
    chk("nop_ready", {ex_ready, wb_en, mem_req}, 3'b100);
    issue(3'b111, 16'hFFFF, 4'b1111, 16'hFFFF, 3'd1);
    chk("op7_ready", {ex_ready, wb_en, mem_req}, 3'b100);
    chk("op7_ccr", ccr, 4'b0100);
    chk("op7_wb_hold", {wb_addr, wb_data}, {3'd6, 16'h1357});
    issue(3'b010, 16'h0300, 4'b0000, 16'h0, 3'd4);
    chk("rst_mid_req", mem_req, 1);
    #2 rst_n = 0; #1;
    chk("rst_mid_drop", {mem_req, ex_ready}, 2'b00);
    chk("rst_mid_ccr", ccr, 0);
    #1 rst_n = 1; #1;
    chk("rst_mid_ready", ex_ready, 1);
    mem_ack = 1; mem_rdata = 16'hDEAD;
    step();
    mem_ack = 0;
    chk("stale_ack", {wb_en, mem_req, ex_ready, mem_err}, 4'b0010);
    chk("stale_wb_data", wb_data, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
